pipe_hazard_ctl: RTL and testbench

PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

---
 rtl/pipe_hazard_ctl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: tracks the instructions in flight after decode,
// stalls decode on a load-use hazard, selects EX operand forwarding sources,
// squashes the youngest stages on a redirect and counts load-use stalls.
module pipe_hazard_ctl #(
  parameter int RW       = 5,
  parameter int DEPTH    = 3,
  parameter int LD_AVAIL = 2,
  parameter int FLUSH_N  = 2,
  parameter int ZERO_REG = 1,
  parameter int CW       = 16,
  localparam int FW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wr,
  input  logic [RW-1:0]    id_wrreg,
  input  logic             id_load,
  input  logic             flush,
  output logic             id_ready,
  output logic [FW-1:0]    fwd_a,
  output logic [FW-1:0]    fwd_b,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CW-1:0]    stall_cnt
);

  // Per-stage payload; the valid bit lives separately so only it is reset.
  typedef struct packed {
    logic          wr;
    logic [RW-1:0] wrreg;
    logic          load;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          rs_used;
    logic          rt_used;
  } rec_t;

  logic [DEPTH:1]   vld_p;
  rec_t             stg_p [1:DEPTH];
  rec_t             in_rec;
  logic             accept;
  logic             ld_use;
  logic [DEPTH-1:0] ld_stage;

  // A valid writer counts only if it targets a real register.
  function automatic logic is_live(input logic v, input rec_t r);
    return v & r.wr & ((ZERO_REG == 0) || (r.wrreg != '0));
  endfunction

  // Saturating increment so the counter parks at all-ones.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign accept      = id_valid & id_ready & ~flush;
  assign stage_valid = vld_p;

  // Decode record entering EX; a non-accepted slot becomes a bubble.
  always_comb begin
    in_rec         = '0;
    in_rec.wr      = id_wr & accept;
    in_rec.wrreg   = id_wrreg;
    in_rec.load    = id_load & accept;
    in_rec.rs      = id_rs;
    in_rec.rt      = id_rt;
    in_rec.rs_used = id_rs_used;
    in_rec.rt_used = id_rt_used;
  end

  // Load-use detection: a load whose data does not yet exist blocks a reader in decode.
  always_comb begin
    ld_use   = 1'b0;
    ld_stage = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      ld_stage[k-1] = is_live(vld_p[k], stg_p[k]) & stg_p[k].load;
    end
    for (int k = 1; k < LD_AVAIL; k++) begin
      if (ld_stage[k-1] &&
          ((id_rs_used && (stg_p[k].wrreg == id_rs)) ||
           (id_rt_used && (stg_p[k].wrreg == id_rt)))) begin
        ld_use = 1'b1;
      end
    end
    id_ready = ~(id_valid & ld_use);
  end

  // Forward select: scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH; k >= 2; k--) begin
      if (is_live(vld_p[k], stg_p[k])) begin
        if (vld_p[1] && stg_p[1].rs_used && (stg_p[k].wrreg == stg_p[1].rs)) begin
          fwd_a = FW'(k - 1);
        end
        if (vld_p[1] && stg_p[1].rt_used && (stg_p[k].wrreg == stg_p[1].rt)) begin
          fwd_b = FW'(k - 1);
        end
      end
    end
  end

  // Control state: stage valid bits shift (youngest squashed on flush) and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p     <= '0;
      stall_cnt <= '0;
    end else begin
      vld_p[1] <= accept;
      for (int k = 2; k <= DEPTH; k++) begin
        vld_p[k] <= vld_p[k-1] & ~(flush && (k <= FLUSH_N));
      end
      if (id_valid && !id_ready && !flush) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  // Payload shift; no reset needed since every use is qualified by the valid bit.
  always_ff @(posedge clk) begin
    stg_p[1] <= in_rec;
    for (int k = 2; k <= DEPTH; k++) begin
      stg_p[k] <= stg_p[k-1];
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: table of per-cycle vectors with a scoreboard queue,
// plus hand-written sequences for ZERO_REG=0, counter saturation and async reset.
module tb_pipe_hazard_ctl;

  localparam int RW       = 5;
  localparam int DEPTH    = 3;
  localparam int LD_AVAIL = 2;

  logic clk;
  logic rst_n;

  logic       id_valid, id_rs_used, id_rt_used, id_wr, id_load, flush;
  logic [4:0] id_rs, id_rt, id_wrreg;
  logic       id_ready;
  logic [1:0] fwd_a, fwd_b;
  logic [2:0] stage_valid;
  logic [15:0] stall_cnt;

  logic       z_valid, z_rs_used, z_rt_used, z_wr, z_load, z_flush;
  logic [4:0] z_rs, z_rt, z_wrreg;
  logic       z_ready;
  logic [1:0] z_fwd_a, z_fwd_b;
  logic [2:0] z_stage_valid;
  logic [1:0] z_stall_cnt;

  int vectors    = 0;
  int miscompares = 0;

  pipe_hazard_ctl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr),
    .id_wrreg(id_wrreg), .id_load(id_load), .flush(flush), .id_ready(id_ready),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stage_valid(stage_valid), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctl #(.ZERO_REG(0), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(z_valid), .id_rs(z_rs), .id_rt(z_rt),
    .id_rs_used(z_rs_used), .id_rt_used(z_rt_used), .id_wr(z_wr),
    .id_wrreg(z_wrreg), .id_load(z_load), .flush(z_flush), .id_ready(z_ready),
    .fwd_a(z_fwd_a), .fwd_b(z_fwd_b), .stage_valid(z_stage_valid), .stall_cnt(z_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [2:0]  sv;
    logic [15:0] sc;
  } exp_t;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       rsu, rtu, wr;
    logic [4:0] wd;
    logic       ld, fl;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t sbq[$];

  function automatic vec_t mk(int v, int rs, int rt, int rsu, int rtu, int wr, int wd,
                              int ld, int fl, int rdy, int fa, int fb, int sv, int sc);
    vec_t r;
    r.v = 1'(v);   r.rs = 5'(rs);   r.rt = 5'(rt);
    r.rsu = 1'(rsu); r.rtu = 1'(rtu); r.wr = 1'(wr);
    r.wd = 5'(wd); r.ld = 1'(ld);   r.fl = 1'(fl);
    r.e.rdy = 1'(rdy); r.e.fa = 2'(fa); r.e.fb = 2'(fb);
    r.e.sv = 3'(sv); r.e.sc = 16'(sc);
    return r;
  endfunction

  function automatic vec_t idle(int fa, int fb, int sv, int sc);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, fa, fb, sv, sc);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic wr,
                       input logic [4:0] wd, input logic ld, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_wr = wr; id_wrreg = wd; id_load = ld; flush = fl;
  endtask

  task automatic zdrive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic wr,
                        input logic [4:0] wd, input logic ld);
    z_valid = v; z_rs = rs; z_rt = rt; z_rs_used = rsu; z_rt_used = rtu;
    z_wr = wr; z_wrreg = wd; z_load = ld; z_flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A forward must never pick a load whose data is not yet available.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fwd_a != 0 && int'(fwd_a) < LD_AVAIL) begin
        chk("fwd_a_unready_load", {31'd0, dut.ld_stage[fwd_a]}, 32'd0);
      end
      if (fwd_b != 0 && int'(fwd_b) < LD_AVAIL) begin
        chk("fwd_b_unready_load", {31'd0, dut.ld_stage[fwd_b]}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    zdrive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;

    // in-flight bundle: v rs rt rsu rtu wr wd ld fl | rdy fa fb sv sc
    // back-to-back dependency: forward from stage 2
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 2, 0, 0,  1, 0, 0, 'b000, 0));
    vecs.push_back(mk(1, 2, 4, 1, 1, 1, 3, 0, 0,  1, 0, 0, 'b001, 0));
    vecs.push_back(idle(1, 0, 'b011, 0));
    vecs.push_back(idle(0, 0, 'b110, 0));
    vecs.push_back(idle(0, 0, 'b100, 0));
    // one independent instruction between: forward from WB stage
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 2, 0, 0,  1, 0, 0, 'b000, 0));
    vecs.push_back(mk(1, 7, 8, 1, 1, 1, 6, 0, 0,  1, 0, 0, 'b001, 0));
    vecs.push_back(mk(1, 2, 4, 1, 1, 1, 3, 0, 0,  1, 0, 0, 'b011, 0));
    vecs.push_back(idle(2, 0, 'b111, 0));
    vecs.push_back(idle(0, 0, 'b110, 0));
    vecs.push_back(idle(0, 0, 'b100, 0));
    // load-use: one stall cycle, then forward from WB
    vecs.push_back(mk(1, 2, 0, 1, 0, 1, 1, 1, 0,  1, 0, 0, 'b000, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 5, 0, 0,  0, 0, 0, 'b001, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 5, 0, 0,  1, 0, 0, 'b010, 1));
    vecs.push_back(idle(2, 2, 'b101, 1));
    vecs.push_back(idle(0, 0, 'b010, 1));
    vecs.push_back(idle(0, 0, 'b100, 1));
    // register 0: no forward, no load-use stall
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0, 0,  1, 0, 0, 'b000, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 7, 0, 0,  1, 0, 0, 'b001, 1));
    vecs.push_back(mk(1, 2, 0, 1, 0, 1, 0, 1, 0,  1, 0, 0, 'b011, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 7, 0, 0,  1, 0, 0, 'b111, 1));
    vecs.push_back(idle(0, 0, 'b111, 1));
    vecs.push_back(idle(0, 0, 'b110, 1));
    vecs.push_back(idle(0, 0, 'b100, 1));
    // full pipe, stalled load-use in decode, flush
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 9, 0, 0,  1, 0, 0, 'b000, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 10, 0, 0, 1, 0, 0, 'b001, 1));
    vecs.push_back(mk(1, 2, 0, 1, 0, 1, 1, 1, 0,  1, 0, 0, 'b011, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 5, 0, 1,  0, 0, 0, 'b111, 1));
    vecs.push_back(idle(0, 0, 'b100, 1));
    vecs.push_back(idle(0, 0, 'b000, 1));
    // two writers of $5: youngest wins; unused source never forwards
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 5, 0, 0,  1, 0, 0, 'b000, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 5, 0, 0,  1, 0, 0, 'b001, 1));
    vecs.push_back(mk(1, 5, 5, 1, 1, 1, 6, 0, 0,  1, 0, 0, 'b011, 1));
    vecs.push_back(mk(1, 5, 5, 0, 1, 1, 7, 0, 0,  1, 1, 1, 'b111, 1));
    vecs.push_back(idle(0, 2, 'b111, 1));
    vecs.push_back(idle(0, 0, 'b110, 1));
    vecs.push_back(idle(0, 0, 'b100, 1));
    // matching sources without id_valid: no stall, no count
    vecs.push_back(mk(1, 2, 0, 1, 0, 1, 3, 1, 0,  1, 0, 0, 'b000, 1));
    vecs.push_back(mk(0, 3, 3, 1, 1, 0, 0, 0, 0,  1, 0, 0, 'b001, 1));
    vecs.push_back(idle(0, 0, 'b010, 1));
    vecs.push_back(idle(0, 0, 'b100, 1));
    vecs.push_back(idle(0, 0, 'b000, 1));

    // reset held: outputs at their reset values even with a request in decode
    repeat (2) @(posedge clk);
    #1;
    drive(1, 1, 1, 1, 1, 1, 2, 0, 0);
    #1;
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    chk("rst_stage_valid", {29'd0, stage_valid}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].rsu, vecs[i].rtu,
            vecs[i].wr, vecs[i].wd, vecs[i].ld, vecs[i].fl);
      sbq.push_back(vecs[i].e);
      #2;
      e = sbq.pop_front();
      chk($sformatf("v%0d.id_ready", i), {31'd0, id_ready}, {31'd0, e.rdy});
      chk($sformatf("v%0d.fwd_a", i), {30'd0, fwd_a}, {30'd0, e.fa});
      chk($sformatf("v%0d.fwd_b", i), {30'd0, fwd_b}, {30'd0, e.fb});
      chk($sformatf("v%0d.stage_valid", i), {29'd0, stage_valid}, {29'd0, e.sv});
      chk($sformatf("v%0d.stall_cnt", i), {16'd0, stall_cnt}, {16'd0, e.sc});
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ZERO_REG=0: register 0 forwards like any other
    zdrive(1, 1, 1, 1, 1, 1, 0, 0);
    tick();
    zdrive(1, 0, 0, 1, 1, 1, 7, 0);
    #1;
    chk("z0_id_ready", {31'd0, z_ready}, 32'd1);
    tick();
    zdrive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("z0_fwd_a", {30'd0, z_fwd_a}, 32'd1);
    chk("z0_fwd_b", {30'd0, z_fwd_b}, 32'd1);
    repeat (3) tick();
    // ZERO_REG=0: a load of register 0 does cause a stall
    zdrive(1, 2, 0, 1, 0, 1, 0, 1);
    tick();
    zdrive(1, 0, 0, 1, 0, 1, 7, 0);
    #1;
    chk("z0_ld_id_ready", {31'd0, z_ready}, 32'd0);
    tick();
    tick();
    zdrive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("z_cnt_1", {30'd0, z_stall_cnt}, 32'd1);
    // saturation of a 2-bit stall counter
    for (int i = 0; i < 4; i++) begin
      zdrive(1, 2, 0, 1, 0, 1, 1, 1);
      tick();
      zdrive(1, 1, 0, 1, 0, 1, 6, 0);
      #1;
      chk($sformatf("z_sat%0d_id_ready", i), {31'd0, z_ready}, 32'd0);
      tick();
      tick();
      zdrive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("z_sat%0d_cnt", i), {30'd0, z_stall_cnt}, (i + 2 > 3) ? 32'd3 : 32'(i + 2));
    end
    repeat (3) tick();

    // asynchronous reset in the middle of a stall, then restart from empty
    drive(1, 2, 0, 1, 0, 1, 1, 1, 0);
    tick();
    drive(1, 1, 1, 1, 1, 1, 5, 0, 0);
    #1;
    chk("ar_pre_id_ready", {31'd0, id_ready}, 32'd0);
    chk("ar_pre_stage_valid", {29'd0, stage_valid}, 32'b001);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_id_ready", {31'd0, id_ready}, 32'd1);
    chk("ar_stage_valid", {29'd0, stage_valid}, 32'd0);
    chk("ar_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("ar_fwd_a", {30'd0, fwd_a}, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ar_post_stage_valid", {29'd0, stage_valid}, 32'b001);
    chk("ar_post_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("ar_post_fwd_a", {30'd0, fwd_a}, 32'd0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
